reg_file_seq_ctrl: RTL and testbench
====================================

Name: reg_file_seq_ctrl

Overview:
- Multi-cycle sequencer driving the 16 x 8-bit register file and ALU of the 8-bit CPU.
- Fetches 16-bit instructions from program memory through a request/valid handshake.
- Drives the register-file read addresses, write address, write enable, ALU op and immediate.
- Resolves branches using the ALU zero flag.

Parameters:
- PC_W, 8, program counter width; wraps modulo 2^PC_W.
- RST_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- instr  in  16  instruction word from program memory.
- instr_valid  in  1  instr is valid this cycle; ignored outside FETCH.
- zero  in  1  ALU result == 0; sampled in EXECUTE.
- fetch_req  out  1  fetch request for address pc.
- pc  out  PC_W  fetch address.
- RA1  out  4  register-file read address 1.
- RA2  out  4  register-file read address 2.
- A3  out  4  register-file write address.
- write_enable  out  1  register-file write strobe.
- alu_op  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 PASSA.
- imm_sel  out  1  ALU B operand = imm instead of RD2.
- imm  out  8  always IR[7:0].
- halted  out  1  core stopped.
- illegal  out  1  undefined opcode trapped (see Optional Feature).

Behaviour:
- Clock and reset:
  - Single clock, clk.
  - rst is synchronous and active-high; it wins over all other events, including mid-instruction.
- Reset values:
  - state FETCH, pc = RST_PC, IR = 0, taken = 0.
  - write_enable 0, halted 0, illegal 0.
  - fetch_req = 1 in the first cycle after reset.
- Instruction format: opcode IR[15:12], rd IR[11:8], rs1 IR[7:4], rs2 IR[3:0], imm8 IR[7:0].
- Opcodes:
  - 0 NOP.
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR: rd <= rs1 op rs2.
  - 6 LDI: rd <= imm8. RA1 = 0, ADD, imm_sel = 1.
  - 7 ADDI: rd <= rd + imm8. RA1 = rd, imm_sel = 1.
  - 8 BEQZ: if rf[rd] == 0 then pc <= imm8. RA1 = rd, PASSA, no write.
  - 9 JMP: pc <= imm8.
  - F HALT.
  - A-E undefined.
- FSM states: FETCH -> DECODE -> EXECUTE -> WRITEBACK -> FETCH; HALT is absorbing.
- FETCH:
  - fetch_req = 1.
  - Wait any number of cycles for instr_valid; on instr_valid, IR <= instr and go to DECODE.
- DECODE: one cycle; RA1/RA2/A3/alu_op/imm_sel become valid from IR.
- EXECUTE:
  - One cycle; taken <= (op == BEQZ && zero) || op == JMP.
  - If op == HALT, go to HALT; pc is not advanced.
- WRITEBACK:
  - One cycle; write_enable = 1 only for opcodes 1-7.
  - pc <= taken ? imm8 : pc + 1, wrapping 0xFF -> 0x00.
- Output validity:
  - RA1/RA2/A3/alu_op/imm_sel are combinational from IR and held stable through DECODE, EXECUTE and WRITEBACK.
  - In FETCH they may change but write_enable = 0.
- Writes to rd = 0 still assert write_enable; the register file discards them.
- Throughput: 4 cycles per instruction when instr_valid is returned in the same cycle as fetch_req.
- HALT state: fetch_req = 0, write_enable = 0, halted = 1; exit only via rst.

Optional Feature:
- Macro: REG_FILE_SEQ_CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - Opcodes A-E go EXECUTE -> HALT with illegal = 1 and halted = 1.
  - pc holds the address of the offending instruction.
- Undefined:
  - Opcodes A-E execute as NOP: no write, pc + 1.
  - illegal is tied to 0.

Test Plan:
- Reset, then program LDI r1,0x05 / LDI r2,0x03 / ADD r3,r1,r2 with instr_valid immediate, plus a reg-file model -> write_enable pulses in cycles 4, 8, 12 with A3 = 1, 2, 3; r3 = 0x08; pc = 3.
- BEQZ r0,0x40 -> pc = 0x40, no write. BEQZ r1,0x40 with r1 = 5 -> pc = old pc + 1.
- instr_valid delayed 5 cycles in FETCH, with junk on instr while invalid -> IR unchanged, fetch_req held high, instruction latched only on the valid cycle.
- JMP 0xFF then NOP at 0xFF -> pc wraps to 0x00.
- HALT at pc 7 -> halted = 1, fetch_req = 0, pc = 7 for 20 cycles. rst high in WRITEBACK of an ADD -> no write, pc = RST_PC, state FETCH next cycle.
- Opcode 0xB with the macro defined -> halted = 1, illegal = 1. Without the macro -> pc + 1, no write, illegal = 0.

Source files
------------

// File: rtl/reg_file_seq_ctrl.sv
// Multi-cycle sequencer for the 8-bit CPU: fetch, decode, execute, writeback over a 16 x 8 register file and ALU.
// Latency: 4 cycles per instruction when instr_valid returns alongside fetch_req; stretched by fetch wait cycles.
// Backpressure: holds FETCH with fetch_req high until instr_valid; HALT is absorbing until rst.
//
// Ports:
//   clk, rst                  clock (rising edge) and synchronous active-high reset
//   instr, instr_valid        program-memory return path, sampled only in FETCH
//   zero                      ALU result == 0, sampled in EXECUTE for BEQZ
//   fetch_req, pc             fetch request and its address
//   RA1, RA2, A3              register-file read/write addresses
//   write_enable              register-file write strobe (WRITEBACK only)
//   alu_op, imm_sel, imm      ALU control and immediate operand
//   halted, illegal           core stopped / stopped on an undefined opcode
//
// Optional build macro REG_FILE_SEQ_CTRL_ILLEGAL_TRAP_EN: opcodes A-E trap into HALT
// with illegal = 1 and pc left on the offending instruction. Without it they behave as NOP.
module reg_file_seq_ctrl #(
    parameter int              PC_W   = 8,
    parameter logic [PC_W-1:0] RST_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [15:0]     instr,
    input  logic            instr_valid,
    input  logic            zero,
    output logic            fetch_req,
    output logic [PC_W-1:0] pc,
    output logic [3:0]      RA1,
    output logic [3:0]      RA2,
    output logic [3:0]      A3,
    output logic            write_enable,
    output logic [2:0]      alu_op,
    output logic            imm_sel,
    output logic [7:0]      imm,
    output logic            halted,
    output logic            illegal
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_LDI  = 4'h6;
    localparam logic [3:0] OP_ADDI = 4'h7;
    localparam logic [3:0] OP_BEQZ = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_XOR   = 3'b100;
    localparam logic [2:0] ALU_PASSA = 3'b101;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     ir_q, ir_d;
    logic            taken_q, taken_d;

    logic [3:0] op;
    logic [3:0] rd;
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic       writes_rf;
    logic       trap_op;

    assign op  = ir_q[15:12];
    assign rd  = ir_q[11:8];
    assign rs1 = ir_q[7:4];
    assign rs2 = ir_q[3:0];
    assign imm = ir_q[7:0];

    // Datapath controls depend only on IR, so they stay stable from DECODE
    // through WRITEBACK and only move when a new word is latched in FETCH.
    always_comb begin
        RA1       = rs1;
        RA2       = rs2;
        A3        = rd;
        alu_op    = ALU_ADD;
        imm_sel   = 1'b0;
        writes_rf = 1'b0;
        case (op)
            OP_ADD:  begin alu_op = ALU_ADD; writes_rf = 1'b1; end
            OP_SUB:  begin alu_op = ALU_SUB; writes_rf = 1'b1; end
            OP_AND:  begin alu_op = ALU_AND; writes_rf = 1'b1; end
            OP_OR:   begin alu_op = ALU_OR;  writes_rf = 1'b1; end
            OP_XOR:  begin alu_op = ALU_XOR; writes_rf = 1'b1; end
            OP_LDI: begin
                // r0 reads as zero, so 0 + imm8 loads the immediate.
                RA1       = 4'h0;
                imm_sel   = 1'b1;
                writes_rf = 1'b1;
            end
            OP_ADDI: begin
                RA1       = rd;
                imm_sel   = 1'b1;
                writes_rf = 1'b1;
            end
            OP_BEQZ: begin
                // PASSA forwards rf[rd] so the ALU zero flag tests it directly.
                RA1    = rd;
                alu_op = ALU_PASSA;
            end
            default: ;
        endcase
    end

`ifdef REG_FILE_SEQ_CTRL_ILLEGAL_TRAP_EN
    assign trap_op = (op >= 4'hA) && (op <= 4'hE);
`else
    assign trap_op = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        taken_d = taken_q;
        case (state_q)
            S_FETCH: begin
                if (instr_valid) begin
                    ir_d    = instr;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                taken_d = ((op == OP_BEQZ) && zero) || (op == OP_JMP);
                // Trapping opcodes leave pc on the instruction that stopped the core.
                if ((op == OP_HALT) || trap_op) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_WRITEBACK;
                end
            end
            S_WRITEBACK: begin
                pc_d    = taken_q ? PC_W'(ir_q[7:0]) : pc_q + PC_W'(1);
                state_d = S_FETCH;
            end
            S_HALT: ;
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= RST_PC;
            ir_q    <= '0;
            taken_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            taken_q <= taken_d;
        end
    end

    assign pc        = pc_q;
    assign fetch_req = (state_q == S_FETCH);
    assign halted    = (state_q == S_HALT);
    // A reset arriving in WRITEBACK must not commit the instruction, so the
    // strobe is killed in the same cycle rst is seen.
    assign write_enable = (state_q == S_WRITEBACK) && writes_rf && !rst;
    // IR is frozen in HALT, so the trapping opcode is still visible there.
    assign illegal = halted && trap_op;

endmodule

// File: tb/tb_reg_file_seq_ctrl.sv
// Directed bench for reg_file_seq_ctrl with a small register-file/ALU model closing the zero loop.
// Latency: checks the 4-cycle instruction rhythm and write strobe cycle numbers.
// Backpressure: exercises a delayed instr_valid, HALT absorption and reset during WRITEBACK.
module tb_reg_file_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] instr = 16'h0000;
    logic        instr_valid = 1'b0;
    logic        zero;
    logic        fetch_req;
    logic [7:0]  pc;
    logic [3:0]  RA1;
    logic [3:0]  RA2;
    logic [3:0]  A3;
    logic        write_enable;
    logic [2:0]  alu_op;
    logic        imm_sel;
    logic [7:0]  imm;
    logic        halted;
    logic        illegal;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_we_cyc = -1;

    always #5 clk = ~clk;

    reg_file_seq_ctrl #(.PC_W(8), .RST_PC(8'h00)) dut (
        .clk          (clk),
        .rst          (rst),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .zero         (zero),
        .fetch_req    (fetch_req),
        .pc           (pc),
        .RA1          (RA1),
        .RA2          (RA2),
        .A3           (A3),
        .write_enable (write_enable),
        .alu_op       (alu_op),
        .imm_sel      (imm_sel),
        .imm          (imm),
        .halted       (halted),
        .illegal      (illegal)
    );

    // Environment: register file (r0 discards writes) and ALU.
    logic [7:0] rf [16] = '{default: 8'h00};
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [7:0] alu_res;

    always_comb begin
        alu_a = rf[RA1];
        alu_b = imm_sel ? imm : rf[RA2];
        case (alu_op)
            3'b000:  alu_res = alu_a + alu_b;
            3'b001:  alu_res = alu_a - alu_b;
            3'b010:  alu_res = alu_a & alu_b;
            3'b011:  alu_res = alu_a | alu_b;
            3'b100:  alu_res = alu_a ^ alu_b;
            3'b101:  alu_res = alu_a;
            default: alu_res = 8'h00;
        endcase
    end
    assign zero = (alu_res == 8'h00);

    always @(posedge clk) begin
        if (write_enable && (A3 != 4'h0)) rf[A3] <= alu_res;
        cyc <= rst ? 0 : cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered and left in FETCH at a sample point (#1 after the edge).
    task automatic run_instr(input logic [15:0] ins, input int dly, input logic [7:0] old_imm,
                             input logic exp_we, input logic [7:0] exp_pc);
        for (int i = 0; i < dly; i++) begin
            instr       = 16'hF0AA;
            instr_valid = 1'b0;
            check("wait_fetch_req", fetch_req, 1);
            check("wait_ir_held", imm, old_imm);
            tick();
        end
        instr       = ins;
        instr_valid = 1'b1;
        check("fetch_req", fetch_req, 1);
        tick();
        instr_valid = 1'b0;
        instr       = 16'hF0AA;
        check("decode_imm", imm, ins[7:0]);
        check("decode_no_req", fetch_req, 0);
        tick();
        tick();
        check("wb_we", write_enable, exp_we);
        if (exp_we) check("wb_a3", A3, ins[11:8]);
        last_we_cyc = write_enable ? cyc + 1 : -1;
        tick();
        check("next_pc", pc, exp_pc);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_fetch_req", fetch_req, 1);
        check("rst_pc", pc, 8'h00);
        check("rst_we", write_enable, 0);
        check("rst_halted", halted, 0);
        check("rst_illegal", illegal, 0);
        check("rst_imm", imm, 8'h00);

        // LDI r1,5 / LDI r2,3 / ADD r3,r1,r2
        run_instr(16'h6105, 0, 8'h00, 1'b1, 8'h01);
        check("ldi1_we_cycle", last_we_cyc, 4);
        run_instr(16'h6203, 0, 8'h00, 1'b1, 8'h02);
        check("ldi2_we_cycle", last_we_cyc, 8);
        run_instr(16'h1312, 0, 8'h00, 1'b1, 8'h03);
        check("add_we_cycle", last_we_cyc, 12);
        check("r1_val", rf[1], 8'h05);
        check("r3_sum", rf[3], 8'h08);

        // BEQZ r0,0x40 taken; BEQZ r1,0x40 not taken (r1 = 5)
        run_instr(16'h8040, 0, 8'h00, 1'b0, 8'h40);
        run_instr(16'h8140, 0, 8'h00, 1'b0, 8'h41);

        // ADDI r1,2 with instr_valid delayed 5 cycles and junk on instr meanwhile
        run_instr(16'h7102, 5, 8'h40, 1'b1, 8'h42);
        check("addi_r1", rf[1], 8'h07);

        // JMP 0xFF then NOP at 0xFF wraps to 0x00
        run_instr(16'h90FF, 0, 8'h00, 1'b0, 8'hFF);
        run_instr(16'h0000, 0, 8'h00, 1'b0, 8'h00);

        // JMP 0x07 then HALT at pc 7
        run_instr(16'h9007, 0, 8'h00, 1'b0, 8'h07);
        instr       = 16'hF000;
        instr_valid = 1'b1;
        tick();
        instr       = 16'h6105;
        tick();
        tick();
        for (int i = 0; i < 20; i++) begin
            check("halt_halted", halted, 1);
            check("halt_no_req", fetch_req, 0);
            check("halt_pc", pc, 8'h07);
            check("halt_we", write_enable, 0);
            tick();
        end
        check("halt_illegal", illegal, 0);
        instr_valid = 1'b0;

        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst2_halted", halted, 0);
        check("rst2_pc", pc, 8'h00);
        check("rst2_fetch_req", fetch_req, 1);

        // ADD r4,r1,r2 with reset landing in WRITEBACK
        instr       = 16'h1412;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("rst_wb_we", write_enable, 0);
        tick();
        rst = 1'b0;
        check("rst_wb_fetch_req", fetch_req, 1);
        check("rst_wb_pc", pc, 8'h00);
        check("rst_wb_r4", rf[4], 8'h00);

        // Undefined opcode 0xB
`ifdef REG_FILE_SEQ_CTRL_ILLEGAL_TRAP_EN
        instr       = 16'hB123;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        tick();
        check("trap_halted", halted, 1);
        check("trap_illegal", illegal, 1);
        check("trap_pc", pc, 8'h00);
        check("trap_no_req", fetch_req, 0);
`else
        run_instr(16'hB123, 0, 8'h00, 1'b0, 8'h01);
        check("undef_illegal", illegal, 0);
        check("undef_halted", halted, 0);
        check("undef_r1", rf[1], 8'h07);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
